// File: rtl/multi_channel_watchdog_if.sv
// rtl/multi_channel_watchdog_if.sv - control and status bundle for the multi-channel watchdog
interface multi_channel_watchdog_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] heartbeat;
    logic [NUM_CH-1:0] window_en;
    logic [NUM_CH-1:0] clear;
    logic [NUM_CH-1:0] warning;
    logic [NUM_CH-1:0] triggered;
    logic [NUM_CH-1:0] early_fault;
    logic              force_reset;
    logic [7:0]        trip_count;

    modport master (
        output enable, heartbeat, window_en, clear,
        input  warning, triggered, early_fault, force_reset, trip_count
    );

    modport slave (
        input  enable, heartbeat, window_en, clear,
        output warning, triggered, early_fault, force_reset, trip_count
    );
endinterface

// File: rtl/multi_channel_watchdog.sv
// rtl/multi_channel_watchdog.sv - per-channel watchdog timers with window check and shared reset pulse
module multi_channel_watchdog #(
    parameter int NUM_CH        = 4,
    parameter int CNT_WIDTH     = 32,
    parameter int TIMEOUT       = 1000,
    parameter int WARN_LEVEL    = 750,
    parameter int WINDOW_MIN    = 0,
    parameter int RST_PULSE_LEN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    multi_channel_watchdog_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, WARN, TRIP} state_t;

    localparam logic [CNT_WIDTH-1:0] WARN_M1   = CNT_WIDTH'(WARN_LEVEL - 1);
    localparam logic [CNT_WIDTH-1:0] TO_M1     = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    // Early test is written as cnt+1 <= WINDOW_MIN so a zero window never folds to a constant compare.
    localparam logic [CNT_WIDTH:0]   WIN_MIN_X = (CNT_WIDTH+1)'(WINDOW_MIN);
    localparam logic [CNT_WIDTH:0]   ONE_X     = (CNT_WIDTH+1)'(1);
    localparam int                   PW        = $clog2(RST_PULSE_LEN + 1);
    localparam logic [PW-1:0]        PULSE_LD  = PW'(RST_PULSE_LEN);
    localparam logic [PW-1:0]        PULSE_ONE = PW'(1);

    state_t               state_q [NUM_CH];
    state_t               state_d [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_q   [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_d   [NUM_CH];
    logic [NUM_CH-1:0]    early_q;
    logic [NUM_CH-1:0]    early_d;
    logic [NUM_CH-1:0]    entering;
    logic [NUM_CH-1:0]    warn_v;
    logic [NUM_CH-1:0]    trip_v;
    logic [PW-1:0]        pulse_q;
    logic [PW-1:0]        pulse_d;
    logic [7:0]           trips_q;
    logic [7:0]           trips_d;
    logic [4:0]           n_new;
    logic [8:0]           trips_sum;

    // Per-channel next state: disable beats everything, then heartbeat (early or valid), then timeout.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            early_d[i]  = early_q[i];
            entering[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                    if (bus.enable[i]) state_d[i] = RUN;
                end
                RUN, WARN: begin
                    if (!bus.enable[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (bus.heartbeat[i] && bus.window_en[i] &&
                                 (({1'b0, cnt_q[i]} + ONE_X) <= WIN_MIN_X)) begin
                        state_d[i]  = TRIP;
                        early_d[i]  = 1'b1;
                        entering[i] = 1'b1;
                    end else if (bus.heartbeat[i]) begin
                        state_d[i] = RUN;
                        cnt_d[i]   = '0;
                    end else if (state_q[i] == WARN && cnt_q[i] == TO_M1) begin
                        state_d[i]  = TRIP;
                        entering[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                        if (state_q[i] == RUN && cnt_q[i] == WARN_M1) state_d[i] = WARN;
                    end
                end
                TRIP: begin
                    if (bus.clear[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                        early_d[i] = 1'b0;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Shared bookkeeping: saturating trip total and a reset pulse that restarts on every new trip.
    always_comb begin
        n_new = '0;
        for (int i = 0; i < NUM_CH; i++) n_new = n_new + 5'(entering[i]);
        trips_sum = {1'b0, trips_q} + {4'b0, n_new};
        trips_d   = trips_sum[8] ? 8'hFF : trips_sum[7:0];
        if (|entering)         pulse_d = PULSE_LD;
        else if (pulse_q != 0) pulse_d = pulse_q - PULSE_ONE;
        else                   pulse_d = '0;
    end

    // State registers; reset dominates everything including an active trip or pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            early_q <= '0;
            pulse_q <= '0;
            trips_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            early_q <= early_d;
            pulse_q <= pulse_d;
            trips_q <= trips_d;
        end
    end

    // Status flags are pure decodes of registered state.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            warn_v[i] = (state_q[i] == WARN);
            trip_v[i] = (state_q[i] == TRIP);
        end
    end

    assign bus.warning     = warn_v;
    assign bus.triggered   = trip_v;
    assign bus.early_fault = early_q;
    assign bus.force_reset = (pulse_q != 0);
    assign bus.trip_count  = trips_q;
endmodule

// File: tb/tb_multi_channel_watchdog.sv
// tb/tb_multi_channel_watchdog.sv - scoreboard bench for multi_channel_watchdog
module tb_multi_channel_watchdog;
    localparam int S_WARN = 0;
    localparam int S_TRIG = 1;
    localparam int S_EARLY = 2;
    localparam int S_FRST = 3;
    localparam int S_TCNT = 4;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    exp_t sb[$];

    multi_channel_watchdog_if #(.NUM_CH(2)) ifc ();

    multi_channel_watchdog #(
        .NUM_CH(2), .CNT_WIDTH(8), .TIMEOUT(16), .WARN_LEVEL(12),
        .WINDOW_MIN(4), .RST_PULSE_LEN(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pick(input int s);
        case (s)
            S_WARN:  return {6'b0, ifc.warning};
            S_TRIG:  return {6'b0, ifc.triggered};
            S_EARLY: return {6'b0, ifc.early_fault};
            S_FRST:  return {7'b0, ifc.force_reset};
            default: return ifc.trip_count;
        endcase
    endfunction

    task automatic expect_at(input int c, input int s, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.sel = s; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every cycle, pop and compare the entries due now; anything overdue is a miss.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [7:0] act;
                act = pick(sb[i].sel);
                checks++;
                if (sb[i].cyc < cyc || act !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %0h expected %0h", sb[i].name, sb[i].cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int r, s, a, b, c;
        ifc.enable = '0; ifc.heartbeat = '0; ifc.window_en = '0; ifc.clear = '0;
        rst = 1'b1;

        // Reset state
        wait_until(3);
        rst = 1'b0;
        expect_at(3, S_WARN, 8'h00, "rst_warning");
        expect_at(3, S_TRIG, 8'h00, "rst_triggered");
        expect_at(3, S_EARLY, 8'h00, "rst_early");
        expect_at(3, S_FRST, 8'h00, "rst_force_reset");
        expect_at(3, S_TCNT, 8'h00, "rst_trip_count");

        // Plain timeout on ch0, then clear and re-arm
        ifc.enable = 2'b01;
        r = cyc + 1;
        expect_at(r + 11, S_WARN, 8'h00, "t1_warn_before");
        expect_at(r + 12, S_WARN, 8'h01, "t1_warn_rise");
        expect_at(r + 15, S_TRIG, 8'h00, "t1_trig_before");
        expect_at(r + 15, S_FRST, 8'h00, "t1_frst_before");
        expect_at(r + 16, S_TRIG, 8'h01, "t1_trig_rise");
        expect_at(r + 16, S_WARN, 8'h00, "t1_warn_in_trip");
        expect_at(r + 16, S_FRST, 8'h01, "t1_frst_1");
        expect_at(r + 18, S_FRST, 8'h01, "t1_frst_3");
        expect_at(r + 19, S_FRST, 8'h00, "t1_frst_end");
        expect_at(r + 16, S_TCNT, 8'h01, "t1_trip_count");
        wait_until(r + 20);
        ifc.clear = 2'b01;
        wait_until(r + 21);
        ifc.clear = 2'b00;
        expect_at(r + 21, S_TRIG, 8'h00, "t1_cleared");
        expect_at(r + 21, S_EARLY, 8'h00, "t1_early_clear");
        expect_at(r + 33, S_WARN, 8'h00, "t1_rearm_warn_before");
        expect_at(r + 34, S_WARN, 8'h01, "t1_rearm_warn_rise");
        wait_until(r + 25);
        ifc.clear = 2'b01;
        wait_until(r + 26);
        ifc.clear = 2'b00;
        wait_until(r + 34);
        ifc.enable = 2'b00;
        expect_at(r + 35, S_WARN, 8'h00, "t1_disable");
        expect_at(r + 35, S_TCNT, 8'h01, "t1_count_hold");

        // Periodic heartbeat keeps ch0 quiet
        wait_until(r + 36);
        s = cyc;
        ifc.enable = 2'b01;
        for (int i = 0; i < 20; i++) begin
            expect_at(s + 10 + 10 * i, S_WARN, 8'h00, "t2_warning");
            expect_at(s + 10 + 10 * i, S_TRIG, 8'h00, "t2_triggered");
            wait_until(s + 10 + 10 * i);
            ifc.heartbeat = 2'b01;
            wait_until(s + 11 + 10 * i);
            ifc.heartbeat = 2'b00;
        end
        wait_until(s + 210);
        ifc.enable = 2'b00;

        // Window mode on ch1: early kick trips, boundary kick is legal
        wait_until(s + 212);
        a = cyc;
        ifc.enable = 2'b10;
        ifc.window_en = 2'b10;
        expect_at(a + 3, S_EARLY, 8'h00, "t3_early_before");
        wait_until(a + 3);
        ifc.heartbeat = 2'b10;
        expect_at(a + 4, S_TRIG, 8'h02, "t3_early_trip");
        expect_at(a + 4, S_EARLY, 8'h02, "t3_early_flag");
        expect_at(a + 4, S_TCNT, 8'h02, "t3_trip_count");
        expect_at(a + 6, S_FRST, 8'h01, "t3_frst_last");
        expect_at(a + 7, S_FRST, 8'h00, "t3_frst_end");
        wait_until(a + 4);
        ifc.heartbeat = 2'b00;
        wait_until(a + 8);
        ifc.clear = 2'b10;
        wait_until(a + 9);
        ifc.clear = 2'b00;
        expect_at(a + 9, S_TRIG, 8'h00, "t3_cleared");
        expect_at(a + 9, S_EARLY, 8'h00, "t3_early_cleared");
        wait_until(a + 14);
        ifc.heartbeat = 2'b10;
        expect_at(a + 15, S_TRIG, 8'h00, "t3_boundary_no_trip");
        expect_at(a + 15, S_EARLY, 8'h00, "t3_boundary_no_early");
        expect_at(a + 26, S_WARN, 8'h00, "t3_warn_before");
        expect_at(a + 27, S_WARN, 8'h02, "t3_warn_rise");
        wait_until(a + 15);
        ifc.heartbeat = 2'b00;
        wait_until(a + 27);
        ifc.enable = 2'b00;
        ifc.window_en = 2'b00;
        expect_at(a + 28, S_WARN, 8'h00, "t3_disable");

        // Last-cycle heartbeat wins, then simultaneous trips
        wait_until(a + 30);
        b = cyc;
        ifc.enable = 2'b11;
        expect_at(b + 16, S_WARN, 8'h03, "t4_both_warn");
        wait_until(b + 16);
        ifc.heartbeat = 2'b01;
        expect_at(b + 17, S_WARN, 8'h00, "t4_warn_after_kick");
        expect_at(b + 17, S_TRIG, 8'h02, "t4_kick_wins");
        expect_at(b + 17, S_TCNT, 8'h03, "t4_count_3");
        expect_at(b + 20, S_FRST, 8'h00, "t4_frst_end_a");
        expect_at(b + 32, S_TRIG, 8'h02, "t4_ch0_before");
        expect_at(b + 33, S_TRIG, 8'h03, "t4_ch0_trip");
        expect_at(b + 33, S_TCNT, 8'h04, "t4_count_4");
        expect_at(b + 36, S_FRST, 8'h00, "t4_frst_end_b");
        wait_until(b + 17);
        ifc.heartbeat = 2'b00;
        wait_until(b + 36);
        ifc.clear = 2'b11;
        wait_until(b + 37);
        ifc.clear = 2'b00;
        expect_at(b + 37, S_TRIG, 8'h00, "t4_both_cleared");
        expect_at(b + 53, S_TCNT, 8'h04, "t4_count_before");
        expect_at(b + 53, S_FRST, 8'h00, "t4_frst_idle");
        expect_at(b + 54, S_TRIG, 8'h03, "t4_both_trip");
        expect_at(b + 54, S_TCNT, 8'h06, "t4_count_plus2");
        expect_at(b + 54, S_FRST, 8'h01, "t4_pulse_1");
        expect_at(b + 56, S_FRST, 8'h01, "t4_pulse_3");
        expect_at(b + 57, S_FRST, 8'h00, "t4_pulse_single");

        // Disable before timeout, pulse extension, reset during pulse
        wait_until(b + 57);
        ifc.clear = 2'b11;
        ifc.enable = 2'b00;
        wait_until(b + 58);
        ifc.clear = 2'b00;
        c = cyc;
        ifc.enable = 2'b01;
        expect_at(c + 15, S_WARN, 8'h01, "t6_warn_at14");
        wait_until(c + 15);
        ifc.enable = 2'b00;
        expect_at(c + 16, S_WARN, 8'h00, "t6_disabled");
        expect_at(c + 16, S_TRIG, 8'h00, "t6_no_trip_a");
        expect_at(c + 17, S_TRIG, 8'h00, "t6_no_trip_b");
        expect_at(c + 17, S_TCNT, 8'h06, "t6_count_hold");
        wait_until(c + 17);
        ifc.enable = 2'b11;
        ifc.window_en = 2'b11;
        wait_until(c + 18);
        ifc.heartbeat = 2'b10;
        expect_at(c + 19, S_TRIG, 8'h02, "t6_ch1_early");
        expect_at(c + 19, S_TCNT, 8'h07, "t6_count_7");
        expect_at(c + 19, S_FRST, 8'h01, "t6_pulse_start");
        wait_until(c + 19);
        ifc.heartbeat = 2'b11;
        expect_at(c + 20, S_TRIG, 8'h03, "t6_ch0_early");
        expect_at(c + 20, S_EARLY, 8'h03, "t6_early_both");
        expect_at(c + 20, S_TCNT, 8'h08, "t6_count_8");
        expect_at(c + 22, S_FRST, 8'h01, "t6_pulse_extended");
        wait_until(c + 22);
        rst = 1'b1;
        ifc.heartbeat = 2'b00;
        ifc.enable = 2'b00;
        ifc.window_en = 2'b00;
        expect_at(c + 23, S_WARN, 8'h00, "t6_rst_warning");
        expect_at(c + 23, S_TRIG, 8'h00, "t6_rst_triggered");
        expect_at(c + 23, S_EARLY, 8'h00, "t6_rst_early");
        expect_at(c + 23, S_FRST, 8'h00, "t6_rst_force_reset");
        expect_at(c + 23, S_TCNT, 8'h00, "t6_rst_trip_count");
        wait_until(c + 23);
        rst = 1'b0;
        expect_at(c + 24, S_TRIG, 8'h00, "t6_post_rst_idle");

        wait_until(c + 27);
        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            errors++;
            $display("FAIL time_limit: got cycle %0d expected completion", cyc);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end
endmodule
